// File: rtl/stage_accum_pkg.sv
// Shared types and default sizing for the stage accumulator.
package stage_accum_pkg;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_CMP = 2'd1,
        ST_RES = 2'd2
    } state_t;

    localparam int DEF_W_DATA   = 13;
    localparam int DEF_W_ACC    = 20;
    localparam int DEF_N_STAGES = 25;
    localparam int DEF_W_STAGE  = 5;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder used for the stage accumulator.
// Build option STAGE_ACCUM_SAT_EN: when defined the sum clamps at the signed
// W-bit limits; when undefined the sum wraps in two's complement.
module sat_add #(
    parameter int W = 20
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

`ifdef STAGE_ACCUM_SAT_EN
    logic signed [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};

    // Overflow shows up as the two top bits of the widened sum disagreeing;
    // the extra top bit then carries the true sign of the result.
    always_comb begin
        sum = wide[W-1:0];
        if (wide[W] != wide[W-1]) begin
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/stage_accum.sv
// Cascade stage accumulator: sums signed leaf values for one stage, compares
// the total against the stage threshold and reports pass/fail per stage.
// Build option STAGE_ACCUM_SAT_EN selects a saturating accumulate (see sat_add).
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   ST_ACC | accepting leaf beats, summing into acc until leaf_last
//   ST_CMP | waiting for the stage threshold, compare on its transfer
//   ST_RES | holding the stage result until res_ready
module stage_accum
    import stage_accum_pkg::*;
#(
    parameter int W_DATA   = DEF_W_DATA,
    parameter int W_ACC    = DEF_W_ACC,
    parameter int N_STAGES = DEF_N_STAGES,
    parameter int W_STAGE  = DEF_W_STAGE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      leaf_valid,
    output logic                      leaf_ready,
    input  logic signed [W_DATA-1:0]  leaf_data,
    input  logic                      leaf_last,
    input  logic                      thr_valid,
    output logic                      thr_ready,
    input  logic signed [W_ACC-1:0]   thr_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_pass,
    output logic                      res_final,
    output logic [W_STAGE-1:0]        res_stage
);

    localparam logic [W_STAGE-1:0] LAST_STAGE = W_STAGE'(N_STAGES - 1);

    state_t                   state;
    logic signed [W_ACC-1:0]  acc;
    logic signed [W_ACC-1:0]  acc_next;
    logic signed [W_ACC-1:0]  leaf_ext;
    logic [W_STAGE-1:0]       stage;
    logic                     leaf_xfer;
    logic                     thr_xfer;
    logic                     res_xfer;
    logic                     pass_now;

    // Ready outputs depend on state alone so no valid-to-ready path exists.
    assign leaf_ready = (state == ST_ACC);
    assign thr_ready  = (state == ST_CMP);

    assign leaf_xfer = leaf_valid & leaf_ready;
    assign thr_xfer  = thr_valid  & thr_ready;
    assign res_xfer  = res_valid  & res_ready;

    assign leaf_ext = {{(W_ACC - W_DATA){leaf_data[W_DATA-1]}}, leaf_data};
    assign pass_now = (acc >= thr_data);

    sat_add #(
        .W (W_ACC)
    ) u_sat_add (
        .a   (acc),
        .b   (leaf_ext),
        .sum (acc_next)
    );

    // Stage FSM with the accumulator, stage counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACC;
            acc       <= '0;
            stage     <= '0;
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
            res_final <= 1'b0;
            res_stage <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (leaf_xfer) begin
                        acc <= acc_next;
                        if (leaf_last) begin
                            state <= ST_CMP;
                        end
                    end
                end
                ST_CMP: begin
                    if (thr_xfer) begin
                        res_pass  <= pass_now;
                        res_final <= ~pass_now | (stage == LAST_STAGE);
                        res_stage <= stage;
                        res_valid <= 1'b1;
                        state     <= ST_RES;
                    end
                end
                ST_RES: begin
                    if (res_xfer) begin
                        res_valid <= 1'b0;
                        acc       <= '0;
                        stage     <= res_final ? '0 : stage + 1'b1;
                        state     <= ST_ACC;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_accum.sv
// Self-checking bench for stage_accum against a plain-arithmetic window model.
module tb_stage_accum;
    import stage_accum_pkg::*;

    localparam int    W_DATA   = DEF_W_DATA;
    localparam int    W_ACC    = DEF_W_ACC;
    localparam int    N_STAGES = DEF_N_STAGES;
    localparam int    W_STAGE  = DEF_W_STAGE;
    localparam longint ACC_MAX = (longint'(1) <<< (W_ACC - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (W_ACC - 1));

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     leaf_valid;
    logic                     leaf_ready;
    logic signed [W_DATA-1:0] leaf_data;
    logic                     leaf_last;
    logic                     thr_valid;
    logic                     thr_ready;
    logic signed [W_ACC-1:0]  thr_data;
    logic                     res_valid;
    logic                     res_ready;
    logic                     res_pass;
    logic                     res_final;
    logic [W_STAGE-1:0]       res_stage;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_acc    = 0;
    int     m_stage  = 0;
    bit     e_pass;
    bit     e_final;
    int     e_stage;

    stage_accum #(
        .W_DATA   (W_DATA),
        .W_ACC    (W_ACC),
        .N_STAGES (N_STAGES),
        .W_STAGE  (W_STAGE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .leaf_valid (leaf_valid),
        .leaf_ready (leaf_ready),
        .leaf_data  (leaf_data),
        .leaf_last  (leaf_last),
        .thr_valid  (thr_valid),
        .thr_ready  (thr_ready),
        .thr_data   (thr_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_pass   (res_pass),
        .res_final  (res_final),
        .res_stage  (res_stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Accumulate in unbounded arithmetic, then apply the build's overflow rule.
    function automatic longint fold(input longint s);
`ifdef STAGE_ACCUM_SAT_EN
        if (s > ACC_MAX) return ACC_MAX;
        if (s < ACC_MIN) return ACC_MIN;
        return s;
`else
        longint span;
        longint r;
        span = longint'(1) <<< W_ACC;
        r = (s - ACC_MIN) % span;
        if (r < 0) r += span;
        return r + ACC_MIN;
`endif
    endfunction

    function automatic longint clamp_thr(input longint t);
        if (t > ACC_MAX) return ACC_MAX;
        if (t < ACC_MIN) return ACC_MIN;
        return t;
    endfunction

    function automatic longint rand_leaf();
        return longint'($urandom_range(0, (1 << W_DATA) - 1)) - (longint'(1) <<< (W_DATA - 1));
    endfunction

    // All tasks start and end on a falling edge.
    task automatic send_leaf(input longint d, input bit last);
        int     waited;
        longint junk;
        waited     = 0;
        junk       = longint'($urandom);
        leaf_valid = 1'b1;
        leaf_data  = d[W_DATA-1:0];
        leaf_last  = last;
        thr_valid  = 1'($urandom_range(0, 1));
        thr_data   = junk[W_ACC-1:0];
        while (!leaf_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!leaf_ready) begin
            chk("leaf_wait", 0, 1);
            leaf_valid = 1'b0;
            thr_valid  = 1'b0;
            return;
        end
        @(posedge clk);
        m_acc = fold(m_acc + d);
        @(negedge clk);
        leaf_valid = 1'b0;
        thr_valid  = 1'b0;
        if (!last) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic issue_thr(input longint t);
        longint junk;
        junk = longint'($urandom);
        chk("thr_ready_cmp", thr_ready, 1);
        chk("leaf_ready_cmp", leaf_ready, 0);
        chk("res_valid_cmp", res_valid, 0);
        leaf_valid = 1'b1;
        leaf_data  = junk[W_DATA-1:0];
        leaf_last  = 1'b1;
        thr_valid  = 1'b1;
        thr_data   = t[W_ACC-1:0];
        e_pass  = (m_acc >= t);
        e_final = !e_pass || (m_stage == N_STAGES - 1);
        e_stage = m_stage;
        @(posedge clk);
        @(negedge clk);
        thr_valid = 1'b0;
        chk("res_valid", res_valid, 1);
        chk("res_pass", res_pass, longint'(e_pass));
        chk("res_final", res_final, longint'(e_final));
        chk("res_stage", res_stage, e_stage);
        chk("thr_ready_res", thr_ready, 0);
        chk("leaf_ready_res", leaf_ready, 0);
    endtask

    task automatic hold_res(input int n);
        longint junk;
        for (int i = 0; i < n; i++) begin
            junk       = longint'($urandom);
            leaf_valid = 1'b1;
            leaf_data  = junk[W_DATA-1:0];
            thr_valid  = 1'b1;
            thr_data   = junk[W_ACC-1:0];
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_pass", res_pass, longint'(e_pass));
            chk("hold_final", res_final, longint'(e_final));
            chk("hold_stage", res_stage, e_stage);
            chk("hold_leaf_ready", leaf_ready, 0);
        end
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready  = 1'b0;
        leaf_valid = 1'b0;
        thr_valid  = 1'b0;
        m_acc   = 0;
        m_stage = e_final ? 0 : m_stage + 1;
        chk("res_valid_after", res_valid, 0);
        chk("leaf_ready_after", leaf_ready, 1);
    endtask

    task automatic do_reset();
        leaf_valid = 1'b0;
        thr_valid  = 1'b0;
        res_ready  = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_acc   = 0;
        m_stage = 0;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_pass", res_pass, 0);
        chk("rst_res_final", res_final, 0);
        chk("rst_res_stage", res_stage, 0);
        chk("rst_leaf_ready", leaf_ready, 1);
        chk("rst_thr_ready", thr_ready, 0);
    endtask

    task automatic run_stage(input longint t, input int hold);
        issue_thr(t);
        hold_res(hold);
        release_res();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     n;
        longint t;

        rst        = 1'b1;
        leaf_valid = 1'b0;
        leaf_data  = '0;
        leaf_last  = 1'b0;
        thr_valid  = 1'b0;
        thr_data   = '0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Pass on stage 0, then the next stage reports index 1 and fails.
        send_leaf(100, 0); send_leaf(-30, 0); send_leaf(50, 1);
        run_stage(120, 1);
        send_leaf(10, 0); send_leaf(20, 1);
        run_stage(31, 0);
        send_leaf(4, 1);
        run_stage(4, 0);

        // Reset mid-stage must drop the partial sum and the stage index.
        send_leaf(-500, 0); send_leaf(-20, 0);
        do_reset();
        send_leaf(7, 1);
        run_stage(7, 0);

        // Reset while the result is back-pressured.
        send_leaf(3, 1);
        issue_thr(0);
        hold_res(2);
        do_reset();
        send_leaf(-1, 1);
        run_stage(0, 5);

        // Randomized stages with thresholds near the running sum.
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) send_leaf(rand_leaf(), k == n - 1);
            t = clamp_thr(m_acc + longint'($urandom_range(0, 100)) - 50);
            run_stage(t, $urandom_range(0, 3));
        end

        // A whole window of passing stages ends with final on the last stage.
        do_reset();
        for (int s = 0; s < N_STAGES + 1; s++) begin
            send_leaf(rand_leaf(), 1);
            run_stage(ACC_MIN, 0);
        end

        // Positive and negative overflow of the accumulator.
        for (int k = 0; k < 130; k++) send_leaf(4095, k == 129);
        run_stage(ACC_MAX, 0);
        for (int k = 0; k < 130; k++) send_leaf(-4096, k == 129);
        run_stage(ACC_MIN + 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_accum.md
STAGE_ACCUM -- requirements
Module: stage_accum

Interface
REQ-001 Parameter W_DATA, default 13, width of one signed leaf value from the failVal/passVal read ports.
REQ-002 Parameter W_ACC, default 20, width of the signed stage accumulator and threshold; W_ACC > W_DATA.
REQ-003 Parameter N_STAGES, default 25, number of cascade stages per window.
REQ-004 Parameter W_STAGE, default 5, stage index width; 2**W_STAGE >= N_STAGES.
REQ-005 clk  input  1  single clock; every register is updated on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 leaf_valid  input  1  leaf value beat valid.
REQ-008 leaf_ready  output  1  leaf value beat accepted.
REQ-009 leaf_data  input  W_DATA  signed leaf value.
REQ-010 leaf_last  input  1  beat is the last feature of the current stage.
REQ-011 thr_valid  input  1  stage threshold valid.
REQ-012 thr_ready  output  1  stage threshold accepted.
REQ-013 thr_data  input  W_ACC  signed stage threshold.
REQ-014 res_valid  output  1  stage result valid.
REQ-015 res_ready  input  1  stage result consumed.
REQ-016 res_pass  output  1  accumulated sum >= threshold.
REQ-017 res_final  output  1  window decision complete: fail, or pass on stage N_STAGES-1.
REQ-018 res_stage  output  W_STAGE  index of the stage this result belongs to.

Function
REQ-019 FSM states are ACC, CMP and RES; a transfer occurs only on a cycle where valid and ready are both 1.
REQ-020 ACC: leaf_ready=1, thr_ready=0, res_valid=0; each leaf transfer updates acc <= acc + sign-extended leaf_data.
REQ-021 ACC -> CMP on a leaf transfer with leaf_last=1; that beat is included in acc.
REQ-022 CMP: leaf_ready=0, thr_ready=1; on a threshold transfer, res_pass <= (updated acc >= thr_data) as a signed compare, then go to RES.
REQ-023 RES: res_valid=1, thr_ready=0, leaf_ready=0; res_pass, res_final and res_stage stay stable until res_ready=1.
REQ-024 res_final is 1 when res_pass=0, or when res_pass=1 and the stage index equals N_STAGES-1.
REQ-025 On a result transfer, acc <= 0 and state <= ACC; stage <= 0 if res_final=1, otherwise stage+1.
REQ-026 Latency: last leaf accepted in cycle T, threshold valid in T+1 -> thr accepted in T+1, res_valid=1 in T+2.
REQ-027 A single-beat stage (leaf_last on the first beat) is legal and behaves as in REQ-021.
REQ-028 Inputs presented while their ready is 0 are ignored, not buffered.
REQ-029 The block adds no combinational path from any valid input to any ready output; ready outputs are decoded from state only.

Reset
REQ-030 With rst=1 at a clock edge: state=ACC, acc=0, stage=0, res_valid=0, res_pass=0, res_final=0, res_stage=0.
REQ-031 Reset asserted in any state, including mid-stage or while RES is back-pressured, discards the partial sum and any pending result.

Configuration
REQ-032 Macro STAGE_ACCUM_SAT_EN defined: the accumulate saturates at the signed W_ACC limits, (2**(W_ACC-1))-1 and -2**(W_ACC-1).
REQ-033 Macro STAGE_ACCUM_SAT_EN undefined: the accumulate wraps modulo 2**W_ACC in two's complement.

Structure
REQ-034 Package stage_accum_pkg holds the state enum type and the default W_DATA, W_ACC, N_STAGES and W_STAGE constants.
REQ-035 One sub-module, sat_add: a signed W_ACC adder whose saturation logic is instantiated only under STAGE_ACCUM_SAT_EN.

Verification
REQ-036 Leaves 100, -30, 50 (last), thr 120 -> res_pass=1, res_final=0, res_stage=0; next stage starts with res_stage=1.
REQ-037 Leaves 10, 20 (last), thr 31 -> res_pass=0, res_final=1; the following stage reports res_stage=0.
REQ-038 N_STAGES=2: stage 0 passes, stage 1 passes -> second result has res_final=1, res_stage=1; counter returns to 0.
REQ-039 Hold res_ready=0 for 5 cycles in RES with leaf_valid=1 -> leaf_ready=0 and outputs stable; the result transfers on the first res_ready=1 cycle.
REQ-040 W_ACC=14, leaves 4095 x3 -> with SAT_EN acc=8191; without SAT_EN acc wraps to -4099 (0x2FFD).
REQ-041 Assert rst during ACC after 2 leaves, then send 1 leaf of 7 (last), thr 7 -> res_pass=1, res_stage=0.
